// File: rtl/flit_demux_1ton.sv
// Wormhole 1-to-N flit demultiplexer. A head flit locks its packet's path to one
// output port until the tail. A single output register is shared by all ports.
module flit_demux_1ton #(
    parameter int unsigned NUM_PORTS = 5,
    parameter int unsigned FLIT_W    = 16,
    parameter int unsigned PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FLIT_W-1:0]    in_flit,
    output logic [NUM_PORTS-1:0] out_valid,
    input  logic [NUM_PORTS-1:0] out_ready,
    output logic [FLIT_W-1:0]    out_flit,
    output logic                 err,
    input  logic                 err_clr,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        DROP   = 2'd2
    } state_e;

    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    state_e                 state_q, state_d;
    logic [PORT_W-1:0]      lock_port_q, lock_port_d;
    logic [PORT_W-1:0]      fwd_port;
    logic [NUM_PORTS-1:0]   out_valid_q;
    logic [FLIT_W-1:0]      out_flit_q;
    logic                   err_q, busy_q;
    logic                   xfer, drain, fwd, set_err, dest_ok, is_head;
    logic [1:0]             ftype;
    logic [PORT_W-1:0]      dest;

    assign ftype   = in_flit[FLIT_W-1 -: 2];
    assign dest    = in_flit[PORT_W-1:0];
    assign dest_ok = 32'(dest) < NUM_PORTS;
    assign is_head = (ftype == T_HEAD) || (ftype == T_HT);

    // out_valid_q is one-hot on the buffered port, so masking selects its ready only
    assign drain    = |(out_valid_q & out_ready);
    assign in_ready = (state_q == DROP) || !(|out_valid_q) || drain;
    assign xfer     = in_valid && in_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lock_port_q <= '0;
        end else begin
            state_q     <= state_d;
            lock_port_q <= lock_port_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        lock_port_d = lock_port_q;
        if (xfer) begin
            case (state_q)
                IDLE: begin
                    if (ftype == T_HEAD) begin
                        if (dest_ok) begin
                            state_d     = LOCKED;
                            lock_port_d = dest;
                        end else begin
                            state_d = DROP;
                        end
                    end
                end
                LOCKED:  if (ftype == T_TAIL) state_d = IDLE;
                DROP:    if (ftype == T_TAIL) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Forward / discard decision for the accepted flit
    always_comb begin
        fwd      = 1'b0;
        fwd_port = lock_port_q;
        set_err  = 1'b0;
        if (xfer) begin
            case (state_q)
                IDLE: begin
                    if (is_head && dest_ok) begin
                        fwd      = 1'b1;
                        fwd_port = dest;
                    end else begin
                        set_err = 1'b1;
                    end
                end
                LOCKED: begin
                    if (is_head) set_err = 1'b1;
                    else         fwd     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output register, sticky error and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= '0;
            out_flit_q  <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            if (fwd) begin
                out_valid_q <= NUM_PORTS'(1) << fwd_port;
                out_flit_q  <= in_flit;
            end else if (drain) begin
                out_valid_q <= '0;
            end
            if (set_err)      err_q <= 1'b1;
            else if (err_clr) err_q <= 1'b0;
            busy_q <= (state_d != IDLE);
        end
    end

    assign out_valid = out_valid_q;
    assign out_flit  = out_flit_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_flit_demux_1ton.sv
// Bench for flit_demux_1ton: directed packet scenarios plus random traffic,
// compared each cycle against a packet-level reference model.
module tb_flit_demux_1ton;

    localparam int unsigned NP = 5;
    localparam int unsigned FW = 16;
    localparam int unsigned PW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] in_flit;
    logic [NP-1:0] out_valid;
    logic [NP-1:0] out_ready;
    logic [FW-1:0] out_flit;
    logic          err;
    logic          err_clr;
    logic          busy;

    int total = 0;
    int bad   = 0;

    // Model: mode 0 = between packets, 1 = routing to m_lock, 2 = dropping
    int            mode;
    int            m_lock;
    bit            m_full;
    int            m_port;
    logic [FW-1:0] m_flit;
    bit            m_err;

    flit_demux_1ton #(.NUM_PORTS(NP), .FLIT_W(FW), .PORT_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_flit(in_flit), .out_valid(out_valid), .out_ready(out_ready),
        .out_flit(out_flit), .err(err), .err_clr(err_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_in_ready();
        return (mode == 2) || !m_full || (out_ready[m_port] == 1'b1);
    endfunction

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input int d);
        logic [FW-1:0] f;
        f          = FW'($urandom);
        f[FW-1 -: 2] = t;
        f[PW-1:0]  = PW'(d);
        return f;
    endfunction

    task automatic model_reset();
        mode = 0; m_lock = 0; m_full = 0; m_port = 0; m_flit = '0; m_err = 0;
    endtask

    task automatic push(input int p);
        m_full = 1; m_port = p; m_flit = in_flit;
    endtask

    // Apply one rising edge to the model using the inputs currently driven
    task automatic model_edge();
        bit acc, set;
        logic [1:0] t;
        int d;
        acc = in_valid && m_in_ready();
        set = 0;
        t   = in_flit[FW-1 -: 2];
        d   = int'(in_flit[PW-1:0]);
        if (m_full && out_ready[m_port]) m_full = 0;
        if (acc) begin
            if (mode == 0) begin
                if ((t == 2'b01 || t == 2'b11) && d < int'(NP)) begin
                    push(d);
                    if (t == 2'b01) begin mode = 1; m_lock = d; end
                end else begin
                    set = 1;
                    if (t == 2'b01) mode = 2;
                end
            end else if (mode == 1) begin
                if (t == 2'b01 || t == 2'b11) set = 1;
                else begin
                    push(m_lock);
                    if (t == 2'b10) mode = 0;
                end
            end else if (t == 2'b10) begin
                mode = 0;
            end
        end
        if (set) m_err = 1;
        else if (err_clr) m_err = 0;
    endtask

    task automatic tick();
        #1;
        if (rst_n) chk("in_ready", 32'(in_ready), 32'(m_in_ready()));
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        chk("out_valid", 32'(out_valid), m_full ? 32'(1) << m_port : 32'(0));
        if (m_full) chk("out_flit", 32'(out_flit), 32'(m_flit));
        chk("err", 32'(err), 32'(m_err));
        chk("busy", 32'(busy), 32'(mode != 0));
    endtask

    task automatic send(input logic [FW-1:0] f, input logic [NP-1:0] r);
        bit done;
        done     = 0;
        in_valid = 1'b1;
        in_flit  = f;
        out_ready = r;
        err_clr  = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            done = m_in_ready();
            tick();
        end
        if (!done) chk("send_timeout", 32'(0), 32'(1));
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = '1;
        err_clr   = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        logic [FW-1:0] h;
        logic [1:0]    t;
        rst_n = 1'b0; in_valid = 1'b0; in_flit = '0; out_ready = '1; err_clr = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_flit", 32'(out_flit), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Packet to port 3 at full rate
        send(mk(2'b01, 3), '1);
        chk("s1_head_ov", 32'(out_valid), 32'h08);
        chk("s1_busy", 32'(busy), 32'(1));
        send(mk(2'b00, 7), '1);
        send(mk(2'b00, 1), '1);
        send(mk(2'b10, 0), '1);
        chk("s1_tail_ov", 32'(out_valid), 32'h08);
        chk("s1_idle", 32'(busy), 32'(0));
        idle(2);

        // Backpressure on port 1 for three cycles
        h = mk(2'b01, 1);
        send(h, '1);
        in_valid = 1'b1; in_flit = mk(2'b00, 4); out_ready = 5'b11101;
        tick();
        chk("s2_in_ready", 32'(in_ready), 32'(0));
        tick(); tick();
        chk("s2_hold", 32'(out_flit), 32'(h));
        chk("s2_hold_ov", 32'(out_valid), 32'h02);
        send(in_flit, '1);
        send(mk(2'b10, 2), '1);
        idle(2);

        // Illegal destination is dropped until the tail
        send(mk(2'b01, 6), '1);
        chk("s3_err", 32'(err), 32'(1));
        chk("s3_busy", 32'(busy), 32'(1));
        send(mk(2'b00, 0), '1);
        send(mk(2'b10, 0), '1);
        chk("s3_idle", 32'(busy), 32'(0));
        idle(1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;

        // Back-to-back single-flit packets
        send(mk(2'b11, 0), '1);
        chk("s4_ov0", 32'(out_valid), 32'h01);
        send(mk(2'b11, 4), '1);
        chk("s4_ov4", 32'(out_valid), 32'h10);
        chk("s4_busy", 32'(busy), 32'(0));
        idle(2);

        // Stray body while idle, then clear
        send(mk(2'b00, 2), '1);
        chk("s5_err_set", 32'(err), 32'(1));
        chk("s5_no_out", 32'(out_valid), 32'(0));
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("s5_err_clr", 32'(err), 32'(0));

        // Reset in the middle of a packet to port 2
        send(mk(2'b01, 2), '1);
        send(mk(2'b01, 0), '1);
        in_valid = 1'b1; in_flit = mk(2'b00, 0); out_ready = '0;
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("s6_ov", 32'(out_valid), 32'(0));
        chk("s6_err", 32'(err), 32'(0));
        chk("s6_busy", 32'(busy), 32'(0));
        chk("s6_in_ready", 32'(in_ready), 32'(1));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        send(mk(2'b01, 0), '1);
        chk("s6_new_head", 32'(out_valid), 32'h01);
        send(mk(2'b10, 0), '1);
        idle(2);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(9) < 7);
            case ($urandom_range(9))
                0, 1, 2: t = 2'b01;
                3:       t = 2'b11;
                4, 5:    t = 2'b10;
                default: t = 2'b00;
            endcase
            in_flit = mk(t, int'($urandom_range(7)));
            for (int p = 0; p < int'(NP); p++) out_ready[p] = ($urandom_range(3) != 0);
            err_clr = ($urandom_range(19) == 0);
            tick();
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flit_demux_1ton.md
FLIT_DEMUX_1TON -- requirements
Module: flit_demux_1toN

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 5: number of output ports, legal 2..16.
REQ-002 SHALL have parameter FLIT_W, default 16: flit width including the 2-bit type field, minimum PORT_W+2.
REQ-003 SHALL have parameter PORT_W, default $clog2(NUM_PORTS): destination field width.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: in_flit is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts in_flit this cycle.
REQ-008 SHALL have port in_flit, input, FLIT_W bits: bits [FLIT_W-1:FLIT_W-2] are the type (00 body, 01 head, 10 tail, 11 head+tail); on a head flit, bits [PORT_W-1:0] are the destination port.
REQ-009 SHALL have port out_valid, output, NUM_PORTS bits: one-hot, at most one bit set.
REQ-010 SHALL have port out_ready, input, NUM_PORTS bits: per-port downstream ready.
REQ-011 SHALL have port out_flit, output, FLIT_W bits: shared data bus, valid for whichever out_valid bit is set.
REQ-012 SHALL have port err, output, 1 bit: sticky protocol-error flag.
REQ-013 SHALL have port err_clr, input, 1 bit: synchronous clear of err.
REQ-014 SHALL have port busy, output, 1 bit: high while a packet path is locked or dropping.

Function
REQ-015 SHALL accept a flit on a transfer, defined as in_valid && in_ready sampled at a rising clk edge.
REQ-016 SHALL hold one output register (flit plus port index); in_ready = !obuf_full || out_ready[obuf_port].
REQ-017 SHALL present an accepted, forwarded flit on out_flit/out_valid the cycle after acceptance: latency 1, full throughput with no bubbles while the selected out_ready is high.
REQ-018 SHALL keep out_flit and out_valid stable while out_valid[p]=1 and out_ready[p]=0.
REQ-019 SHALL ignore out_ready bits of non-selected ports.
REQ-020 SHALL implement the FSM states IDLE, LOCKED, DROP.
REQ-021 SHALL, in IDLE on an accepted head with destination < NUM_PORTS, forward the flit, latch the destination as lock_port, and go to LOCKED.
REQ-022 SHALL, in IDLE on an accepted head with destination >= NUM_PORTS, discard the flit, set err, and go to DROP.
REQ-023 SHALL, in IDLE on an accepted head+tail with a legal destination, forward the flit and stay in IDLE; with an illegal destination it SHALL discard the flit, set err, and stay in IDLE.
REQ-024 SHALL, in IDLE on an accepted body or tail, discard the flit, set err, and stay in IDLE.
REQ-025 SHALL, in LOCKED, forward body flits to lock_port ignoring their low bits, and forward a tail to lock_port then go to IDLE.
REQ-026 SHALL, in LOCKED on an accepted head or head+tail, discard the flit, set err, and remain LOCKED.
REQ-027 SHALL, in DROP, discard every accepted flit, and on a tail go to IDLE; in_ready is 1 in DROP regardless of the output register.
REQ-028 SHALL assert busy in LOCKED and DROP.
REQ-029 SHALL give set priority over err_clr when both occur in the same cycle.
REQ-030 SHALL require no extra cycle between the tail of one packet and the head of the next; a head may be accepted the cycle after the tail.

Reset
REQ-031 SHALL, while rst_n=0 (asynchronously), force state IDLE, out_valid=0, out_flit=0, err=0, busy=0, lock_port=0, and empty the output register.
REQ-032 SHALL leave in_ready=1 after reset; asserting reset mid-packet abandons the packet with no flit delivered after reset.

Verification
REQ-033 SHALL cover this scenario (NUM_PORTS=5, FLIT_W=16): head dest 3, two bodies, tail, all out_ready=1 -> out_valid=5'b01000 for 4 consecutive cycles starting 1 cycle after the head; busy=1 through the tail; IDLE after.
REQ-034 SHALL cover this scenario: head dest 1, then out_ready[1]=0 for 3 cycles -> out_flit held, in_ready=0, no flit lost or duplicated, transfer resumes when out_ready[1]=1.
REQ-035 SHALL cover this scenario: head dest 6 (illegal), body, tail -> no out_valid bit set, err=1, busy=1 until the tail, then IDLE.
REQ-036 SHALL cover this scenario: head+tail dest 0, then head+tail dest 4 back-to-back -> out_valid=00001 then 10000 on consecutive cycles; busy stays 0.
REQ-037 SHALL cover this scenario: body flit while IDLE, then err_clr pulse -> err=1 the cycle after the body, err=0 after err_clr; no output.
REQ-038 SHALL cover this scenario: rst_n pulled low mid-packet on port 2 -> out_valid=0 immediately, err=0; a new head dest 0 routes to port 0.
